// File: rtl/control_unit_hs.sv
// Instruction-sequencing controller: decodes IR, drives datapath strobes
// and handshakes a variable-latency memory through mem_req/mem_ack.
module control_unit_hs #(
   parameter int word_size    = 8,
   parameter int reg_sel_size = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [word_size-1:0]    instruction,
   input  logic                    zero,
   input  logic                    mem_ack,
   input  logic                    start,
   output logic [reg_sel_size:0]   sel_bus_1_mux,
   output logic [1:0]              sel_bus_2_mux,
   output logic [2**reg_sel_size-1:0] load_reg,
   output logic                    load_PC,
   output logic                    inc_PC,
   output logic                    load_IR,
   output logic                    load_add_R,
   output logic                    load_Reg_Y,
   output logic                    load_Reg_Z,
   output logic                    mem_req,
   output logic                    write,
   output logic                    halted,
   output logic                    err
);

   localparam int N  = 2**reg_sel_size;
   localparam int SW = reg_sel_size + 1;

   localparam logic [SW-1:0] SEL_PC = SW'(N);

   localparam logic [1:0] B2_ALU = 2'd0;
   localparam logic [1:0] B2_B1  = 2'd1;
   localparam logic [1:0] B2_MEM = 2'd2;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_RD   = 4'd5;
   localparam logic [3:0] OP_WR   = 4'd6;
   localparam logic [3:0] OP_BR   = 4'd7;
   localparam logic [3:0] OP_BRZ  = 4'd8;
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FET1,
      S_FET2,
      S_DEC,
      S_EX1,
      S_RD1,
      S_RD2,
      S_WR1,
      S_WR2,
      S_BR1,
      S_BR2,
      S_HALT,
      S_ERR
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [3:0]              op;
   logic [reg_sel_size-1:0] src;
   logic [reg_sel_size-1:0] dest;
   logic [N-1:0]            dest_oh;

   logic is_nop;
   logic is_alu;
   logic is_not;
   logic is_rd;
   logic is_wr;
   logic is_br;
   logic is_skip;
   logic is_halt;

   assign op   = instruction[word_size-1 -: 4];
   assign src  = instruction[2*reg_sel_size-1 : reg_sel_size];
   assign dest = instruction[reg_sel_size-1 : 0];

   assign dest_oh = {{(N-1){1'b0}}, 1'b1} << dest;

   // Opcode classes are mutually exclusive; BRZ splits on the zero flag.
   always_comb begin
      is_nop  = (op == OP_NOP);
      is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
      is_not  = (op == OP_NOT);
      is_rd   = (op == OP_RD);
      is_wr   = (op == OP_WR);
      is_br   = (op == OP_BR) || ((op == OP_BRZ) && zero);
      is_skip = (op == OP_BRZ) && !zero;
      is_halt = (op == OP_HALT);
   end

   always_comb begin
      state_d       = state_q;
      sel_bus_1_mux = '0;
      sel_bus_2_mux = B2_ALU;
      load_reg      = '0;
      load_PC       = 1'b0;
      inc_PC        = 1'b0;
      load_IR       = 1'b0;
      load_add_R    = 1'b0;
      load_Reg_Y    = 1'b0;
      load_Reg_Z    = 1'b0;
      mem_req       = 1'b0;
      write         = 1'b0;
      halted        = 1'b0;
      err           = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            halted = 1'b1;
            if (start) state_d = S_FET1;
         end

         S_FET1: begin
            sel_bus_1_mux = SEL_PC;
            sel_bus_2_mux = B2_B1;
            load_add_R    = 1'b1;
            state_d       = S_FET2;
         end

         S_FET2: begin
            mem_req       = 1'b1;
            sel_bus_2_mux = B2_MEM;
            if (mem_ack) begin
               load_IR = 1'b1;
               inc_PC  = 1'b1;
               state_d = S_DEC;
            end
         end

         S_DEC: begin
            unique case (1'b1)
               is_nop: state_d = S_FET1;
               is_alu: begin
                  sel_bus_1_mux = {1'b0, src};
                  load_Reg_Y    = 1'b1;
                  state_d       = S_EX1;
               end
               is_not: begin
                  sel_bus_1_mux = {1'b0, src};
                  sel_bus_2_mux = B2_ALU;
                  load_Reg_Z    = 1'b1;
                  load_reg      = dest_oh;
                  state_d       = S_FET1;
               end
               is_rd, is_wr, is_br: begin
                  sel_bus_1_mux = SEL_PC;
                  sel_bus_2_mux = B2_B1;
                  load_add_R    = 1'b1;
                  if (is_rd)      state_d = S_RD1;
                  else if (is_wr) state_d = S_WR1;
                  else            state_d = S_BR1;
               end
               is_skip: begin
                  inc_PC  = 1'b1;
                  state_d = S_FET1;
               end
               is_halt: state_d = S_HALT;
               default: state_d = S_ERR;
            endcase
         end

         S_EX1: begin
            sel_bus_1_mux = {1'b0, dest};
            sel_bus_2_mux = B2_ALU;
            load_Reg_Z    = 1'b1;
            load_reg      = dest_oh;
            state_d       = S_FET1;
         end

         S_RD1, S_WR1, S_BR1: begin
            mem_req       = 1'b1;
            sel_bus_2_mux = B2_MEM;
            if (mem_ack) begin
               load_add_R = 1'b1;
               inc_PC     = (state_q != S_BR1);
               if (state_q == S_RD1)      state_d = S_RD2;
               else if (state_q == S_WR1) state_d = S_WR2;
               else                       state_d = S_BR2;
            end
         end

         S_RD2: begin
            mem_req       = 1'b1;
            sel_bus_2_mux = B2_MEM;
            if (mem_ack) begin
               load_reg = dest_oh;
               state_d  = S_FET1;
            end
         end

         S_WR2: begin
            mem_req       = 1'b1;
            write         = 1'b1;
            sel_bus_1_mux = {1'b0, src};
            if (mem_ack) state_d = S_FET1;
         end

         // Operand word holds the address of the branch target.
         S_BR2: begin
            mem_req       = 1'b1;
            sel_bus_2_mux = B2_MEM;
            if (mem_ack) begin
               load_PC = 1'b1;
               state_d = S_FET1;
            end
         end

         S_HALT: begin
            halted = 1'b1;
            if (start) state_d = S_FET1;
         end

         S_ERR: begin
            halted = 1'b1;
            err    = 1'b1;
         end

         default: state_d = S_ERR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

endmodule

// File: tb/tb_control_unit_hs.sv
// Directed vector bench for control_unit_hs: per-cycle input records
// with hand-computed expected outputs, plus an async-reset sequence.
module tb_control_unit_hs;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] instruction = 8'h00;
   logic       zero = 1'b0;
   logic       mem_ack = 1'b0;
   logic       start = 1'b0;
   logic [2:0] sel_bus_1_mux;
   logic [1:0] sel_bus_2_mux;
   logic [3:0] load_reg;
   logic       load_PC, inc_PC, load_IR;
   logic       load_add_R, load_Reg_Y, load_Reg_Z;
   logic       mem_req, write, halted, err;

   control_unit_hs #(.word_size(8), .reg_sel_size(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .instruction   (instruction),
      .zero          (zero),
      .mem_ack       (mem_ack),
      .start         (start),
      .sel_bus_1_mux (sel_bus_1_mux),
      .sel_bus_2_mux (sel_bus_2_mux),
      .load_reg      (load_reg),
      .load_PC       (load_PC),
      .inc_PC        (inc_PC),
      .load_IR       (load_IR),
      .load_add_R    (load_add_R),
      .load_Reg_Y    (load_Reg_Y),
      .load_Reg_Z    (load_Reg_Z),
      .mem_req       (mem_req),
      .write         (write),
      .halted        (halted),
      .err           (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] sel1;
      logic [1:0] sel2;
      logic [3:0] lreg;
      logic [5:0] strb;
      logic       req;
      logic       wr;
      logic       hlt;
      logic       er;
   } out_t;

   typedef struct {
      string name;
      logic  rst;
      logic  start;
      logic [7:0] ir;
      logic  zero;
      logic  ack;
      out_t  exp;
   } vec_t;

   // strobe bits: {load_PC, inc_PC, load_IR, load_add_R, load_Reg_Y, load_Reg_Z}
   localparam int SP = 32;
   localparam int SI = 16;
   localparam int SR = 8;
   localparam int SA = 4;
   localparam int SY = 2;
   localparam int SZ = 1;

   vec_t vecs[$];
   int   checks = 0;
   int   failures = 0;

   function automatic out_t mk(int s1, int s2, int lr, int st,
                               int rq, int w, int h, int e);
      out_t o;
      o.sel1 = 3'(s1);
      o.sel2 = 2'(s2);
      o.lreg = 4'(lr);
      o.strb = 6'(st);
      o.req  = 1'(rq);
      o.wr   = 1'(w);
      o.hlt  = 1'(h);
      o.er   = 1'(e);
      return o;
   endfunction

   function automatic void add(string nm, int r, int s, int ir, int z,
                               int a, out_t e);
      vec_t v;
      v.name  = nm;
      v.rst   = 1'(r);
      v.start = 1'(s);
      v.ir    = 8'(ir);
      v.zero  = 1'(z);
      v.ack   = 1'(a);
      v.exp   = e;
      vecs.push_back(v);
   endfunction

   function automatic out_t act();
      return {sel_bus_1_mux, sel_bus_2_mux, load_reg,
              {load_PC, inc_PC, load_IR, load_add_R, load_Reg_Y, load_Reg_Z},
              mem_req, write, halted, err};
   endfunction

   task automatic chk(input string nm, input out_t e);
      out_t a;
      a = act();
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, a, e);
      end
   endtask

   task automatic drive(input int r, input int s, input int ir,
                        input int z, input int a);
      @(negedge clk);
      rst         = 1'(r);
      start       = 1'(s);
      instruction = 8'(ir);
      zero        = 1'(z);
      mem_ack     = 1'(a);
      #1;
   endtask

   out_t IDL, F1, F2A, F2W;

   initial begin
      IDL = mk(0, 0, 0, 0, 0, 0, 1, 0);
      F1  = mk(4, 1, 0, SA, 0, 0, 0, 0);
      F2A = mk(0, 2, 0, SR + SI, 1, 0, 0, 0);
      F2W = mk(0, 2, 0, 0, 1, 0, 0, 0);

      // reset and start
      add("rst",        1, 0, 8'h00, 0, 1, IDL);
      add("idle_start", 0, 1, 8'h00, 0, 1, IDL);
      add("a_fet1",     0, 0, 8'h00, 0, 1, F1);
      add("a_fet2",     0, 0, 8'h00, 0, 1, F2A);
      add("a_dec_nop",  0, 0, 8'h00, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
      // ADD src=2 dest=3
      add("b_fet1",     0, 0, 8'h1B, 0, 1, F1);
      add("b_fet2",     0, 0, 8'h1B, 0, 1, F2A);
      add("b_dec_add",  0, 0, 8'h1B, 0, 1, mk(2, 0, 0, SY, 0, 0, 0, 0));
      add("b_ex1",      0, 0, 8'h1B, 0, 1, mk(3, 0, 8, SZ, 0, 0, 0, 0));
      // RD dest=2, two wait cycles per access
      add("c_fet1",     0, 0, 8'h52, 0, 0, F1);
      add("c_fet2_w1",  0, 0, 8'h52, 0, 0, F2W);
      add("c_fet2_w2",  0, 0, 8'h52, 0, 0, F2W);
      add("c_fet2_ack", 0, 0, 8'h52, 0, 1, F2A);
      add("c_dec_rd",   0, 0, 8'h52, 0, 0, F1);
      add("c_rd1_w1",   0, 0, 8'h52, 0, 0, F2W);
      add("c_rd1_w2",   0, 0, 8'h52, 0, 0, F2W);
      add("c_rd1_ack",  0, 0, 8'h52, 0, 1, mk(0, 2, 0, SA + SI, 1, 0, 0, 0));
      add("c_rd2_w1",   0, 0, 8'h52, 0, 0, F2W);
      add("c_rd2_w2",   0, 0, 8'h52, 0, 0, F2W);
      add("c_rd2_ack",  0, 0, 8'h52, 0, 1, mk(0, 2, 4, 0, 1, 0, 0, 0));
      add("c_cyc12",    0, 0, 8'h52, 0, 0, F1);
      // BRZ taken (one wait in BR1), then untaken
      add("d_fet2",     0, 0, 8'h80, 1, 1, F2A);
      add("d_dec_z1",   0, 0, 8'h80, 1, 1, F1);
      add("d_br1_w",    0, 0, 8'h80, 0, 0, F2W);
      add("d_br1_ack",  0, 0, 8'h80, 0, 1, mk(0, 2, 0, SA, 1, 0, 0, 0));
      add("d_br2_ack",  0, 0, 8'h80, 0, 1, mk(0, 2, 0, SP, 1, 0, 0, 0));
      add("d_fet1",     0, 0, 8'h80, 0, 1, F1);
      add("d_fet2b",    0, 0, 8'h80, 0, 1, F2A);
      add("d_dec_z0",   0, 0, 8'h80, 0, 1, mk(0, 0, 0, SI, 0, 0, 0, 0));
      add("d_skip_f1",  0, 0, 8'h80, 0, 1, F1);
      // WR src=1
      add("e_fet2",     0, 0, 8'h64, 0, 1, F2A);
      add("e_dec_wr",   0, 0, 8'h64, 0, 1, F1);
      add("e_wr1_ack",  0, 0, 8'h64, 0, 1, mk(0, 2, 0, SA + SI, 1, 0, 0, 0));
      add("e_wr2_w",    0, 0, 8'h64, 0, 0, mk(1, 0, 0, 0, 1, 1, 0, 0));
      add("e_wr2_ack",  0, 1, 8'h64, 0, 1, mk(1, 0, 0, 0, 1, 1, 0, 0));
      add("e_fet1",     0, 0, 8'h64, 0, 1, F1);
      // HALT then resume with NOT src=1 dest=2
      add("f_fet2",     0, 0, 8'hF0, 0, 1, F2A);
      add("f_dec_halt", 0, 0, 8'hF0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
      add("f_halt1",    0, 0, 8'hF0, 0, 1, IDL);
      add("f_halt2",    0, 0, 8'hF0, 0, 0, IDL);
      add("f_halt_go",  0, 1, 8'hF0, 0, 0, IDL);
      add("f_fet1",     0, 0, 8'h46, 0, 1, F1);
      add("f_fet2b",    0, 0, 8'h46, 0, 1, F2A);
      add("f_dec_not",  0, 0, 8'h46, 0, 1, mk(1, 0, 4, SZ, 0, 0, 0, 0));
      add("f_fet1b",    0, 0, 8'hA0, 0, 1, F1);
      // illegal opcode
      add("g_fet2",     0, 0, 8'hA0, 0, 1, F2A);
      add("g_dec_ill",  0, 0, 8'hA0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
      add("g_err1",     0, 1, 8'hA0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 1));
      add("g_err2",     0, 1, 8'hF0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 1));
      add("g_err3",     0, 0, 8'h00, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 1));
      add("g_rst",      1, 0, 8'h00, 0, 1, IDL);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].start, vecs[i].ir,
               vecs[i].zero, vecs[i].ack);
         chk(vecs[i].name, vecs[i].exp);
      end

      // reset asserted in the middle of a WR2 wait cycle
      drive(0, 1, 8'h64, 0, 0); chk("h_idle", IDL);
      drive(0, 0, 8'h64, 0, 0); chk("h_fet1", F1);
      drive(0, 0, 8'h64, 0, 1); chk("h_fet2", F2A);
      drive(0, 0, 8'h64, 0, 1); chk("h_dec", F1);
      drive(0, 0, 8'h64, 0, 1);
      chk("h_wr1", mk(0, 2, 0, SA + SI, 1, 0, 0, 0));
      drive(0, 0, 8'h64, 0, 0);
      chk("h_wr2_w", mk(1, 0, 0, 0, 1, 1, 0, 0));
      #2 rst = 1'b1;
      #1 chk("h_async_rst", IDL);
      drive(0, 0, 8'h64, 0, 1); chk("h_hold_idle", IDL);
      drive(0, 0, 8'h64, 0, 1); chk("h_idle_nostart", IDL);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
